// File: rtl/cnn_test_pkg.sv
// Shared types and default sizing for the CNN on-chip test sequencer.
package cnn_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_CHECK,
    ST_HOLD,
    ST_REST,
    ST_DONE
  } cnn_test_state_e;

  localparam int CNN_OUT_WIDTH      = 160;
  localparam int DEF_NUM_TESTS      = 10;
  localparam int DEF_SETTLE_CYCLES  = 20;
  localparam int DEF_HOLD_CYCLES    = 3;
  localparam int DEF_REST_CYCLES    = 20;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cnn_test_sequencer_cycle_counter.sv
// Loadable down-counter; stops at zero and flags it. Load wins over counting.
module cycle_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_lower,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero_o
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk_i or negedge reset_lower) begin
    if (!reset_lower) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero_o = (count == '0);

endmodule

// File: rtl/cnn_test_sequencer.sv
// Hardware self-test: drives the CNN through NUM_TESTS inferences, checks each
// result against a 1-cycle synchronous expected-output ROM, and tallies results.
module cnn_test_sequencer
  import cnn_test_pkg::*;
#(
  parameter int DATA_WIDTH     = CNN_OUT_WIDTH,
  parameter int NUM_TESTS      = DEF_NUM_TESTS,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int REST_CYCLES    = DEF_REST_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IW = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
  localparam int CW = $clog2(NUM_TESTS + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_lower,
  input  logic                  run_i,
  output logic                  begin_o,
  input  logic                  cnn_valid_i,
  input  logic [DATA_WIDTH-1:0] cnn_data_i,
  output logic [IW-1:0]         exp_addr_o,
  input  logic [DATA_WIDTH-1:0] exp_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [CW-1:0]         pass_count_o,
  output logic [CW-1:0]         fail_count_o,
  output logic                  first_fail_valid_o,
  output logic [IW-1:0]         first_fail_idx_o,
  output logic                  timeout_o,
  output logic [DATA_WIDTH-1:0] last_result_o
);

  localparam int PW = $clog2(max3(SETTLE_CYCLES, HOLD_CYCLES, REST_CYCLES) + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  cnn_test_state_e state;
  logic            run_q, valid_q;
  logic            run_rise, valid_rise, last_test, wait_expired;
  logic            ph_load, ph_zero, to_load, to_zero;
  logic [PW-1:0]   ph_val;

  assign run_rise     = run_i & ~run_q;
  assign valid_rise   = cnn_valid_i & ~valid_q;
  assign last_test    = (exp_addr_o == IW'(NUM_TESTS - 1));
  assign wait_expired = (state == ST_WAIT) && to_zero && !valid_rise;
  assign to_load      = (state == ST_ARM) && ph_zero;

  // The phase counter is loaded on the same edge the state changes, so each
  // phase sees its own count from its first cycle.
  always_comb begin
    ph_load = 1'b0;
    ph_val  = PW'(SETTLE_CYCLES - 1);
    case (state)
      ST_IDLE:  ph_load = run_rise;
      ST_WAIT: begin
        ph_load = wait_expired;
        ph_val  = PW'(REST_CYCLES - 1);
      end
      ST_CHECK: begin
        ph_load = 1'b1;
        ph_val  = PW'(HOLD_CYCLES - 1);
      end
      ST_HOLD: begin
        ph_load = ph_zero;
        ph_val  = PW'(REST_CYCLES - 1);
      end
      ST_REST:  ph_load = ph_zero;
      default:  ph_load = 1'b0;
    endcase
  end

  cycle_counter #(.WIDTH(PW)) u_phase (
    .clk_i       (clk_i),
    .reset_lower (reset_lower),
    .load        (ph_load),
    .load_val    (ph_val),
    .zero_o      (ph_zero)
  );

  cycle_counter #(.WIDTH(TW)) u_timeout (
    .clk_i       (clk_i),
    .reset_lower (reset_lower),
    .load        (to_load),
    .load_val    (TW'(TIMEOUT_CYCLES - 1)),
    .zero_o      (to_zero)
  );

  always_ff @(posedge clk_i or negedge reset_lower) begin
    if (!reset_lower) begin
      state              <= ST_IDLE;
      run_q              <= 1'b0;
      valid_q            <= 1'b0;
      begin_o            <= 1'b0;
      exp_addr_o         <= '0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
      pass_o             <= 1'b0;
      pass_count_o       <= '0;
      fail_count_o       <= '0;
      first_fail_valid_o <= 1'b0;
      first_fail_idx_o   <= '0;
      timeout_o          <= 1'b0;
      last_result_o      <= '0;
    end else begin
      run_q   <= run_i;
      valid_q <= cnn_valid_i;
      if (busy_o && !run_i) begin
        // Abort keeps partial results readable.
        state   <= ST_IDLE;
        begin_o <= 1'b0;
        busy_o  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (run_rise) begin
            state              <= ST_ARM;
            begin_o            <= 1'b1;
            busy_o             <= 1'b1;
            exp_addr_o         <= '0;
            pass_count_o       <= '0;
            fail_count_o       <= '0;
            first_fail_valid_o <= 1'b0;
            first_fail_idx_o   <= '0;
            timeout_o          <= 1'b0;
            last_result_o      <= '0;
          end
          ST_ARM: if (ph_zero) state <= ST_WAIT;
          ST_WAIT: begin
            if (valid_rise) begin
              last_result_o <= cnn_data_i;
              state         <= ST_CHECK;
            end else if (to_zero) begin
              fail_count_o       <= fail_count_o + CW'(1);
              timeout_o          <= 1'b1;
              first_fail_valid_o <= 1'b1;
              if (!first_fail_valid_o) first_fail_idx_o <= exp_addr_o;
              begin_o            <= 1'b0;
              state              <= ST_REST;
            end
          end
          ST_CHECK: begin
            if (last_result_o == exp_data_i) begin
              pass_count_o <= pass_count_o + CW'(1);
            end else begin
              fail_count_o       <= fail_count_o + CW'(1);
              first_fail_valid_o <= 1'b1;
              if (!first_fail_valid_o) first_fail_idx_o <= exp_addr_o;
            end
            state <= ST_HOLD;
          end
          ST_HOLD: if (ph_zero) begin
            begin_o <= 1'b0;
            state   <= ST_REST;
          end
          ST_REST: if (ph_zero) begin
            if (last_test) begin
              state  <= ST_DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              pass_o <= (fail_count_o == '0);
            end else begin
              exp_addr_o <= exp_addr_o + IW'(1);
              begin_o    <= 1'b1;
              state      <= ST_ARM;
            end
          end
          ST_DONE: if (!run_i) begin
            state  <= ST_IDLE;
            done_o <= 1'b0;
            pass_o <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnn_test_sequencer.sv
// Directed campaigns against a timeline model of the sequencer; every cycle of
// each campaign is compared, plus literal end-of-campaign expectations.
module tb_cnn_test_sequencer;

  localparam int DW = 160, NT = 4, SET = 20, HOLD = 3, REST = 20, TO = 64;
  localparam int D = 50, LEN = 400;
  localparam int M_OK = 0, M_BAD = 1, M_NONE = 2, M_STUCK = 3, M_PULSE = 4;

  logic          clk = 1'b0, reset_lower = 1'b0, run = 1'b0, cnn_valid = 1'b0;
  logic [DW-1:0] cnn_data = '0, exp_data = '0;
  logic          begin_o, busy_o, done_o, pass_o, first_fail_valid_o, timeout_o;
  logic [1:0]    exp_addr_o, first_fail_idx_o;
  logic [2:0]    pass_count_o, fail_count_o;
  logic [DW-1:0] last_result_o;

  cnn_test_sequencer #(
    .DATA_WIDTH(DW), .NUM_TESTS(NT), .SETTLE_CYCLES(SET), .HOLD_CYCLES(HOLD),
    .REST_CYCLES(REST), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .reset_lower(reset_lower), .run_i(run), .begin_o(begin_o),
    .cnn_valid_i(cnn_valid), .cnn_data_i(cnn_data), .exp_addr_o(exp_addr_o),
    .exp_data_i(exp_data), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .pass_count_o(pass_count_o), .fail_count_o(fail_count_o),
    .first_fail_valid_o(first_fail_valid_o), .first_fail_idx_o(first_fail_idx_o),
    .timeout_o(timeout_o), .last_result_o(last_result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] rom [NT];
  int            mode [NT];
  initial for (int k = 0; k < NT; k++) rom[k] = {5{32'h1234_5678 + 32'h1111_1111 * 32'(k)}};
  always @(posedge clk) exp_data <= rom[exp_addr_o];

  int n_chk = 0, n_pass = 0, s_cyc = 0;
  bit model_on = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s r=%0d actual=%0h required=%0h", name, cyc - s_cyc, act, exp);
  endtask

  // CNN stand-in: reacts to begin_o; per-test behaviour chosen by mode[].
  int bk = 0, tidx = -1;
  bit stuck = 1;
  always @(negedge clk) begin
    if (begin_o) begin
      if (bk == 0) tidx = tidx + 1;
      bk = bk + 1;
    end else begin
      if (bk != 0) stuck = 0;
      bk = 0;
    end
    if (tidx >= 0 && tidx < NT)
      cnn_data = rom[tidx] ^ {{(DW-1){1'b0}}, mode[tidx] == M_BAD};
    cnn_valid = stuck || (begin_o && tidx >= 0 && tidx < NT &&
                (((mode[tidx] == M_OK || mode[tidx] == M_BAD || mode[tidx] == M_PULSE) && bk >= D) ||
                 (mode[tidx] == M_PULSE && (bk == 5 || bk == 6))));
  end

  // Expected outputs per cycle relative to the first begin_o cycle.
  bit            eb [LEN], ebusy [LEN], edone [LEN], efv [LEN], etm [LEN];
  int            epc [LEN], efc [LEN], efi [LEN], eaddr [LEN];
  logic [DW-1:0] elr [LEN];

  task automatic build_model(input int a, output int done_at);
    int t, nxt, p, pc, fc, fi;
    bit fv, tm;
    t = 0; pc = 0; fc = 0; fi = 0; fv = 0; tm = 0;
    for (int r = 0; r < LEN; r++) begin
      eb[r] = 0; ebusy[r] = 0; edone[r] = 0; efv[r] = 0; etm[r] = 0;
      epc[r] = 0; efc[r] = 0; efi[r] = 0; eaddr[r] = 0; elr[r] = '0;
    end
    for (int k = 0; k < NT; k++) begin
      for (int r = t; r < LEN; r++) eaddr[r] = k;
      if (mode[k] == M_NONE || mode[k] == M_STUCK) begin
        for (int r = t; r < t + SET + TO; r++) eb[r] = 1;
        p = t + SET + TO;
        fc++; tm = 1;
        if (!fv) begin fv = 1; fi = k; end
        nxt = p + REST;
      end else begin
        p = t + D;
        for (int r = p; r < LEN; r++) elr[r] = rom[k] ^ {{(DW-1){1'b0}}, mode[k] == M_BAD};
        for (int r = t; r <= p + HOLD; r++) eb[r] = 1;
        p = p + 1;
        if (mode[k] == M_BAD) begin
          fc++;
          if (!fv) begin fv = 1; fi = k; end
        end else pc++;
        nxt = p + HOLD + REST;
      end
      for (int r = p; r < LEN; r++) begin
        epc[r] = pc; efc[r] = fc; efi[r] = fi; efv[r] = fv; etm[r] = tm;
      end
      for (int r = t; r < nxt; r++) ebusy[r] = 1;
      t = nxt;
    end
    for (int r = t; r < LEN; r++) edone[r] = 1;
    done_at = t;
    if (a >= 0) begin
      for (int r = a; r < LEN; r++) begin
        eb[r] = 0; ebusy[r] = 0; edone[r] = 0;
        epc[r] = epc[a-1]; efc[r] = efc[a-1]; efi[r] = efi[a-1]; efv[r] = efv[a-1];
        etm[r] = etm[a-1]; eaddr[r] = eaddr[a-1]; elr[r] = elr[a-1];
      end
    end
  endtask

  always @(negedge clk) begin : compare
    int r;
    r = cyc - s_cyc;
    if (model_on && r >= 0 && r < LEN) begin
      check("begin", DW'(begin_o), DW'(eb[r]));
      check("busy", DW'(busy_o), DW'(ebusy[r]));
      check("done", DW'(done_o), DW'(edone[r]));
      check("pass_flag", DW'(pass_o), DW'(edone[r] && efc[r] == 0));
      check("pass_count", DW'(pass_count_o), DW'(epc[r]));
      check("fail_count", DW'(fail_count_o), DW'(efc[r]));
      check("first_fail_valid", DW'(first_fail_valid_o), DW'(efv[r]));
      check("first_fail_idx", DW'(first_fail_idx_o), DW'(efi[r]));
      check("timeout", DW'(timeout_o), DW'(etm[r]));
      check("exp_addr", DW'(exp_addr_o), DW'(eaddr[r]));
      check("last_result", last_result_o, elr[r]);
    end
  end

  task automatic set_modes(input int m0, input int m1, input int m2, input int m3);
    mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3;
  endtask

  task automatic start();
    @(negedge clk);
    tidx = -1; run = 1; s_cyc = cyc + 1; model_on = 1;
  endtask

  task automatic run_full(input int want_at, input int pc, input int fc, input int fi, input int tm);
    int done_at, r;
    build_model(-1, done_at);
    check("model_done_cycle", DW'(done_at), DW'(want_at));
    start();
    r = -1;
    while (!done_o && r < LEN) begin
      @(negedge clk);
      r = cyc - s_cyc;
    end
    check("done_cycle", DW'(r), DW'(want_at));
    repeat (3) @(negedge clk);
    check("final_pass_count", DW'(pass_count_o), DW'(pc));
    check("final_fail_count", DW'(fail_count_o), DW'(fc));
    check("final_first_fail_idx", DW'(first_fail_idx_o), DW'(fi));
    check("final_first_fail_valid", DW'(first_fail_valid_o), DW'(fc > 0));
    check("final_timeout", DW'(timeout_o), DW'(tm));
    check("final_pass_flag", DW'(pass_o), DW'(fc == 0));
    model_on = 0; run = 0;
    @(negedge clk);
    check("done_cleared", DW'(done_o), DW'(0));
    check("results_kept", DW'(pass_count_o), DW'(pc));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_begin"}, DW'(begin_o), '0);
    check({tag, "_busy"}, DW'(busy_o), '0);
    check({tag, "_done"}, DW'(done_o), '0);
    check({tag, "_pass"}, DW'(pass_o), '0);
    check({tag, "_counts"}, DW'({pass_count_o, fail_count_o}), '0);
    check({tag, "_first_fail"}, DW'({first_fail_valid_o, first_fail_idx_o}), '0);
    check({tag, "_timeout"}, DW'(timeout_o), '0);
    check({tag, "_addr"}, DW'(exp_addr_o), '0);
    check({tag, "_last_result"}, last_result_o, '0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int done_at;
    set_modes(M_STUCK, M_PULSE, M_OK, M_OK);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_lower = 1;
    repeat (2) @(negedge clk);

    // valid stuck high into WAIT of test 0, pulse during ARM of test 1
    run_full(326, 3, 1, 0, 1);
    set_modes(M_OK, M_OK, M_OK, M_OK);
    run_full(296, 4, 0, 0, 0);
    set_modes(M_OK, M_OK, M_BAD, M_OK);
    run_full(296, 3, 1, 2, 0);
    set_modes(M_OK, M_NONE, M_OK, M_OK);
    run_full(326, 3, 1, 1, 1);

    // abort in HOLD of test 1: edge at r=124, HOLD r=125..127, run low sampled at r=126
    set_modes(M_OK, M_OK, M_OK, M_OK);
    build_model(126, done_at);
    start();
    repeat (126) @(negedge clk);
    run = 0;
    @(negedge clk);
    check("abort_begin", DW'(begin_o), '0);
    check("abort_busy", DW'(busy_o), '0);
    check("abort_done", DW'(done_o), '0);
    check("abort_pass_count", DW'(pass_count_o), DW'(2));
    model_on = 0;
    repeat (3) @(negedge clk);
    run_full(296, 4, 0, 0, 0);

    // asynchronous reset mid-WAIT of test 0
    build_model(-1, done_at);
    start();
    repeat (31) @(negedge clk);
    check("pre_reset_begin", DW'(begin_o), DW'(1));
    model_on = 0;
    #2 reset_lower = 0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset_lower = 1; run = 0;
    repeat (2) @(negedge clk);
    run_full(296, 4, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cnn_test_sequencer.md
# cnn_test_sequencer

Synthesizable on-chip test sequencer that runs the CNN through a campaign of `NUM_TESTS` inferences and checks each result against a synchronous expected-output ROM. It sits in the lower clock domain beside the CNN core. It drives the CNN's begin input, watches `valid`, and compares the output word against the ROM entry. It reports pass/fail counts, the first failing index, and timeouts, replacing bench-only checking with a hardware self-test.

## Interface
Parameters:
- `DATA_WIDTH`, 160: width of the CNN output word and of each ROM entry.
- `NUM_TESTS`, 10: number of test vectors, ≥1.
- `SETTLE_CYCLES`, 20: cycles `begin_o` is held high before a `valid` rising edge is accepted.
- `HOLD_CYCLES`, 3: cycles `begin_o` stays high after a result is checked.
- `REST_CYCLES`, 20: cycles `begin_o` is held low between tests.
- `TIMEOUT_CYCLES`, 4096: maximum wait for `valid`, in cycles.

Ports:
- `clk_i`, in, 1: clock.
- `reset_lower`, in, 1: reset, asynchronous, active-low.
- `run_i`, in, 1: level. Rising edge starts a campaign; low aborts it.
- `begin_o`, out, 1: begin/enable to the CNN.
- `cnn_valid_i`, in, 1: CNN output-valid.
- `cnn_data_i`, in, `DATA_WIDTH`: CNN output word.
- `exp_addr_o`, out, `$clog2(NUM_TESTS)`: ROM address, equal to the current test index.
- `exp_data_i`, in, `DATA_WIDTH`: ROM read data, 1-cycle synchronous latency.
- `busy_o`, out, 1: campaign in progress.
- `done_o`, out, 1: campaign complete. Held until `run_i` goes low.
- `pass_o`, out, 1: valid with `done_o`. High when `fail_count_o`==0.
- `pass_count_o` / `fail_count_o`, out, `$clog2(NUM_TESTS+1)` each: result counters.
- `first_fail_valid_o`, out, 1: a failure has been recorded this campaign.
- `first_fail_idx_o`, out, `$clog2(NUM_TESTS)`: index of the first failing test.
- `timeout_o`, out, 1: sticky. At least one test timed out.
- `last_result_o`, out, `DATA_WIDTH`: last captured CNN word.

## Operation
- States: IDLE, ARM, WAIT, CHECK, HOLD, REST, DONE.
- IDLE:
  - `begin_o`=0.
  - A rising edge of `run_i` clears all counters, flags, `last_result_o` and the test index to 0, then enters ARM.
- ARM:
  - `begin_o`=1 for `SETTLE_CYCLES` cycles, then enters WAIT.
  - `valid` edges seen during ARM are ignored.
- WAIT:
  - `begin_o`=1.
  - Rising edge of `cnn_valid_i` means `cnn_valid_i`=1 while the registered `valid_q`=0. `valid_q` tracks the input in every state and resets to 0.
  - On an edge, capture `cnn_data_i` into `last_result_o`, then enter CHECK.
  - A level that is already high on entry is not an edge.
  - If the wait counter reaches `TIMEOUT_CYCLES`-1 with no edge: count a fail, set `timeout_o`, record the first failure, then enter REST (HOLD is skipped).
- CHECK, one cycle:
  - Compare `last_result_o` with `exp_data_i` over all bits.
  - Equal: increment `pass_count_o`. Otherwise: increment `fail_count_o`, and load `first_fail_idx_o` if `first_fail_valid_o`=0, then set `first_fail_valid_o`.
  - Next state is HOLD.
- HOLD: `begin_o`=1 for `HOLD_CYCLES` cycles, then enter REST.
- REST:
  - `begin_o`=0 for `REST_CYCLES` cycles.
  - If the index equals `NUM_TESTS`-1, enter DONE. Otherwise increment the index and enter ARM.
- DONE:
  - `done_o`=1, `begin_o`=0, results frozen.
  - `run_i` low returns to IDLE and clears `done_o`. Results stay readable until the next start.
- Abort: `run_i` low in ARM, WAIT, CHECK, HOLD or REST goes to IDLE next cycle. `begin_o` drops that cycle; `done_o` is not set and the partial counts are kept.
- `busy_o`=1 in ARM, WAIT, CHECK, HOLD and REST.
- `exp_addr_o` follows the index. It is stable from ARM onward, so ROM data is valid by CHECK because `SETTLE_CYCLES` ≥1.
- Counters cannot overflow: their width holds `NUM_TESTS`, and `pass_count_o`+`fail_count_o` ≤ `NUM_TESTS`.

## Timing
- Reset: all outputs 0, state IDLE, `valid_q`=0. Reset is asynchronous and takes effect in any state, mid-campaign included.
- All outputs are registered.
- `begin_o` rises on the first clock after the `run_i` rising edge.
- Valid edge in cycle t: `last_result_o` is updated at t+1 (CHECK), and the counters are updated at t+2.
- Per-test cycle count: `SETTLE_CYCLES` + wait + 1 + `HOLD_CYCLES` + `REST_CYCLES`.
- `done_o` rises the cycle after the last REST cycle.
- A `valid` edge arriving in the same cycle as a timeout counts as a capture, not a timeout.

## Structure
- Package `cnn_test_pkg`: state enum `cnn_test_state_e`, and default parameter constants (`CNN_OUT_WIDTH`=160, default cycle counts).
- Sub-module `cycle_counter`: a loadable down-counter with a `zero_o` flag. One instance is shared by ARM, HOLD and REST; a second serves the WAIT timeout.

## Test plan
- `NUM_TESTS`=4, CNN model returns the ROM values, `valid` asserted 50 cycles after `begin_o` → `pass_count_o`=4, `fail_count_o`=0, `pass_o`=1, `done_o`=1.
- Test 2 returns the ROM word with bit 0 flipped → `fail_count_o`=1, `first_fail_idx_o`=2, `first_fail_valid_o`=1, `pass_o`=0.
- `TIMEOUT_CYCLES`=64, no `valid` on test 1 → `timeout_o`=1, `fail_count_o`=1, `first_fail_idx_o`=1, and the campaign still completes 4 tests.
- `valid` held high from reset into WAIT → no capture, then timeout. A `valid` pulse during ARM → ignored.
- `run_i` dropped during HOLD of test 1 → `begin_o`=0 next cycle, state IDLE, `done_o`=0, `pass_count_o`=2 retained. A new `run_i` edge clears the counts to 0.
- `reset_lower` asserted mid-WAIT → all outputs 0 immediately. After release, a new `run_i` edge runs a full campaign correctly.
